// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Package     : decode_pkg
// Description : Shared types for the Decode -> Execute handoff bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

    localparam int DATA_WIDTH    = 18;
    localparam int VECTOR_SIZE   = 8;
    localparam int ADDRESS_WIDTH = 4;
    localparam int OPCODE_WIDTH  = 5;

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0]                  opcode;
        logic [ADDRESS_WIDTH-1:0]                 rd;
        logic [ADDRESS_WIDTH-1:0]                 rs1;
        logic [ADDRESS_WIDTH-1:0]                 rs2;
        logic [DATA_WIDTH-1:0]                    s1;
        logic [DATA_WIDTH-1:0]                    s2;
        logic [DATA_WIDTH-1:0]                    imm;
        logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0]   v1;
        logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0]   v2;
    } decode_bundle_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

endpackage
`default_nettype wire

// File: rtl/decode_execute_buffer.sv
`default_nettype none
// ============================================================================
// Module      : decode_execute_buffer
// Description : Two-entry skid buffer between Decode and Execute with flush
//               and a saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_execute_buffer
    import decode_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  decode_bundle_t          in_bundle,
    output logic                    out_valid,
    input  logic                    out_ready,
    output decode_bundle_t          out_bundle,
    output logic [STALL_CNT_W-1:0]  stall_cycles
);

    buf_state_t                 r_state;
    buf_state_t                 w_state_nxt;
    decode_bundle_t             r_main;
    decode_bundle_t             r_skid;
    logic [STALL_CNT_W-1:0]     r_stall;

    logic                       w_in_fire;
    logic                       w_out_fire;
    logic                       w_load_main_in;
    logic                       w_load_main_skid;
    logic                       w_load_skid;

    // Ready is a pure decode of registered state, so Execute back-pressure
    // never reaches Decode combinationally.
    assign in_ready     = (r_state != TWO);
    assign out_valid    = (r_state != EMPTY);
    assign out_bundle   = r_main;
    assign stall_cycles = r_stall;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt    = ONE;
                    w_load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_main_in = 1'b1;
                end else if (w_in_fire) begin
                    w_state_nxt = TWO;
                    w_load_skid = 1'b1;
                end else if (w_out_fire) begin
                    w_state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (w_out_fire) begin
                    w_state_nxt      = ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
        // Flush only drops validity; payload flops keep whatever they hold.
        if (flush) begin
            w_state_nxt      = EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
            r_stall <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_main_in) begin
                r_main <= in_bundle;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_bundle;
            end
            if (out_valid && !out_ready && (r_stall != '1)) begin
                r_stall <= r_stall + STALL_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_execute_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_execute_buffer
// Description : Randomised self-checking bench against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_execute_buffer;
    import decode_pkg::*;

    logic            clock;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            out_ready;
    decode_bundle_t  in_bundle;
    logic            in_ready;
    logic            out_valid;
    decode_bundle_t  out_bundle;
    logic [15:0]     stall_cycles;
    logic            sat_in_ready;
    logic            sat_out_valid;
    decode_bundle_t  sat_out_bundle;
    logic [3:0]      sat_stall;

    int total = 0;
    int bad   = 0;

    decode_bundle_t  m_q[$];
    longint          m_stall;

    decode_execute_buffer #(.STALL_CNT_W(16)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_bundle(in_bundle),
        .out_valid(out_valid), .out_ready(out_ready), .out_bundle(out_bundle),
        .stall_cycles(stall_cycles)
    );

    decode_execute_buffer #(.STALL_CNT_W(4)) dut_sat (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(sat_in_ready), .in_bundle(in_bundle),
        .out_valid(sat_out_valid), .out_ready(out_ready), .out_bundle(sat_out_bundle),
        .stall_cycles(sat_stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic decode_bundle_t rand_bundle();
        decode_bundle_t b;
        b.opcode = OPCODE_WIDTH'($urandom());
        b.rd     = ADDRESS_WIDTH'($urandom());
        b.rs1    = ADDRESS_WIDTH'($urandom());
        b.rs2    = ADDRESS_WIDTH'($urandom());
        b.s1     = DATA_WIDTH'($urandom());
        b.s2     = DATA_WIDTH'($urandom());
        b.imm    = DATA_WIDTH'($urandom());
        for (int i = 0; i < VECTOR_SIZE; i++) begin
            b.v1[i] = DATA_WIDTH'($urandom());
            b.v2[i] = DATA_WIDTH'($urandom());
        end
        return b;
    endfunction

    function automatic longint sat_val(longint n, int w);
        longint lim;
        lim = (longint'(1) << w) - 1;
        return (n > lim) ? lim : n;
    endfunction

    // One clock edge; the model advances from the inputs present at the edge.
    task automatic tick();
        bit can_take;
        bit has_head;
        @(posedge clock);
        if (!reset) begin
            m_q.delete();
            m_stall = 0;
        end else begin
            can_take = (m_q.size() < 2);
            has_head = (m_q.size() > 0);
            if (has_head && !out_ready) m_stall++;
            if (flush) begin
                m_q.delete();
            end else begin
                if (has_head && out_ready) void'(m_q.pop_front());
                if (in_valid && can_take) m_q.push_back(in_bundle);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_bundle = '0;
        tick(); tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid actual=%0b required=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready actual=%0b required=1", in_ready); end
        total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL reset_stall actual=%0d required=0", stall_cycles); end
        total++; if (out_bundle !== '0) begin bad++; $display("FAIL reset_out_bundle actual=%h required=0", out_bundle); end
        #2 reset = 1'b1;
        tick();
    endtask

    task automatic test_streaming();
        decode_bundle_t b;
        out_ready = 1'b1; flush = 1'b0;
        for (int k = 0; k < 8; k++) begin
            b = rand_bundle();
            b.opcode = OPCODE_WIDTH'(k);
            in_bundle = b; in_valid = 1'b1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready k=%0d actual=%0b required=1", k, in_ready); end
            tick();
            total++; if (out_valid !== 1'b1 || out_bundle.opcode !== OPCODE_WIDTH'(k)) begin
                bad++; $display("FAIL stream_opcode k=%0d actual valid=%0b op=%0d required valid=1 op=%0d", k, out_valid, out_bundle.opcode, k);
            end
            total++; if (out_bundle !== b) begin bad++; $display("FAIL stream_bundle k=%0d actual=%h required=%h", k, out_bundle, b); end
        end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain actual=%0b required=0", out_valid); end
    endtask

    task automatic test_backpressure();
        decode_bundle_t a, b, c;
        decode_bundle_t got[$];
        logic [15:0] s0;
        bit accepted;
        a = rand_bundle(); b = rand_bundle(); c = rand_bundle();
        s0 = stall_cycles;
        out_ready = 1'b0;
        in_bundle = a; in_valid = 1'b1; tick();
        in_bundle = b; tick();
        in_bundle = c;
        for (int i = 0; i < 3; i++) begin
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready i=%0d actual=%0b required=0", i, in_ready); end
            tick();
        end
        total++; if (out_bundle !== a) begin bad++; $display("FAIL bp_head actual=%h required=%h", out_bundle, a); end
        total++; if (stall_cycles !== s0 + 16'd4) begin bad++; $display("FAIL bp_stall actual=%0d required=%0d", stall_cycles, s0 + 16'd4); end
        out_ready = 1'b1;
        for (int i = 0; i < 10 && got.size() < 3; i++) begin
            if (out_valid) got.push_back(out_bundle);
            accepted = in_valid && in_ready;
            tick();
            if (accepted) in_valid = 1'b0;
        end
        total++; if (got.size() != 3) begin bad++; $display("FAIL bp_count actual=%0d required=3", got.size()); end
        else begin
            total++; if (got[0] !== a || got[1] !== b || got[2] !== c) begin
                bad++; $display("FAIL bp_order actual=%h,%h,%h", got[0].opcode, got[1].opcode, got[2].opcode);
            end
        end
        in_valid = 1'b0;
        tick();
        total++; if (stall_cycles !== s0 + 16'd4) begin bad++; $display("FAIL bp_stall_after actual=%0d required=%0d", stall_cycles, s0 + 16'd4); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty actual=%0b required=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; flush = 1'b0;
        in_bundle = rand_bundle(); in_valid = 1'b1; tick();
        in_bundle = rand_bundle(); tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_two actual=%0b required=0", in_ready); end
        in_bundle = rand_bundle(); flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_two_valid actual=%0b required=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_two_ready actual=%0b required=1", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_d_leak i=%0d actual=%0b required=0", i, out_valid); end
        end
        out_ready = 1'b0;
        in_bundle = rand_bundle(); in_valid = 1'b1; tick();
        in_bundle = rand_bundle(); flush = 1'b1; out_ready = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_one_valid actual=%0b required=0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_one_leak actual=%0b required=0", out_valid); end
    endtask

    task automatic test_payload();
        decode_bundle_t b;
        b = rand_bundle();
        for (int i = 0; i < VECTOR_SIZE; i++) b.v1[i] = DATA_WIDTH'(18'h3FFFF - i);
        b.imm = 18'h20001;
        b.rd  = 4'hF;
        out_ready = 1'b1; flush = 1'b0;
        in_bundle = b; in_valid = 1'b1; tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL payload_valid actual=%0b required=1", out_valid); end
        total++; if (out_bundle.v1[7] !== 18'h3FFF8) begin bad++; $display("FAIL payload_lane7 actual=%h required=3fff8", out_bundle.v1[7]); end
        total++; if (out_bundle.v1[0] !== 18'h3FFFF) begin bad++; $display("FAIL payload_lane0 actual=%h required=3ffff", out_bundle.v1[0]); end
        total++; if (out_bundle.imm !== 18'h20001) begin bad++; $display("FAIL payload_imm actual=%h required=20001", out_bundle.imm); end
        total++; if (out_bundle.rd !== 4'hF) begin bad++; $display("FAIL payload_rd actual=%h required=f", out_bundle.rd); end
        total++; if (out_bundle !== b) begin bad++; $display("FAIL payload_bundle actual=%h required=%h", out_bundle, b); end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_bundle = rand_bundle();
            total++; if (in_ready !== (m_q.size() < 2) || sat_in_ready !== (m_q.size() < 2)) begin
                bad++; $display("FAIL rand_in_ready n=%0d actual=%0b/%0b required=%0b", n, in_ready, sat_in_ready, m_q.size() < 2);
            end
            total++; if (out_valid !== (m_q.size() > 0) || sat_out_valid !== (m_q.size() > 0)) begin
                bad++; $display("FAIL rand_out_valid n=%0d actual=%0b/%0b required=%0b", n, out_valid, sat_out_valid, m_q.size() > 0);
            end
            if (m_q.size() > 0) begin
                total++; if (out_bundle !== m_q[0] || sat_out_bundle !== m_q[0]) begin
                    bad++; $display("FAIL rand_bundle n=%0d actual=%h required=%h", n, out_bundle, m_q[0]);
                end
            end
            total++; if (stall_cycles !== 16'(sat_val(m_stall, 16)) || sat_stall !== 4'(sat_val(m_stall, 4))) begin
                bad++; $display("FAIL rand_stall n=%0d actual=%0d/%0d required=%0d/%0d", n, stall_cycles, sat_stall,
                                sat_val(m_stall, 16), sat_val(m_stall, 4));
            end
            tick();
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; flush = 1'b0;
        in_bundle = rand_bundle(); in_valid = 1'b1; tick();
        in_bundle = rand_bundle(); tick();
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            bad++; $display("FAIL areset_pre actual ready=%0b valid=%0b required ready=0 valid=1", in_ready, out_valid);
        end
        #2 reset = 1'b0;
        #1;
        m_q.delete(); m_stall = 0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_valid actual=%0b required=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL areset_ready actual=%0b required=1", in_ready); end
        total++; if (stall_cycles !== 16'd0 || sat_stall !== 4'd0) begin
            bad++; $display("FAIL areset_stall actual=%0d/%0d required=0", stall_cycles, sat_stall);
        end
        tick();
        #2 reset = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_release actual=%0b required=0", out_valid); end
    endtask

    task automatic test_saturation();
        out_ready = 1'b0; flush = 1'b0;
        in_bundle = rand_bundle(); in_valid = 1'b1; tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            total++; if (sat_stall !== 4'((i > 15) ? 15 : i)) begin
                bad++; $display("FAIL sat_stall4 i=%0d actual=%0d required=%0d", i, sat_stall, (i > 15) ? 15 : i);
            end
        end
        total++; if (stall_cycles !== 16'd25) begin bad++; $display("FAIL sat_stall16 actual=%0d required=25", stall_cycles); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sat_valid actual=%0b required=1", out_valid); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_payload();
        test_random();
        test_async_reset();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
